// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes for all ALU clients and the multiplier sequencer state type.
package alu_pkg;

   localparam int unsigned F_W     = 5;
   localparam int unsigned SHAMT_W = 5;

   localparam logic [F_W-1:0] F_AND = 5'b00000;
   localparam logic [F_W-1:0] F_OR  = 5'b00001;
   localparam logic [F_W-1:0] F_ADD = 5'b00010;
   localparam logic [F_W-1:0] F_SLL = 5'b00011;
   localparam logic [F_W-1:0] F_XOR = 5'b00100;
   localparam logic [F_W-1:0] F_NOR = 5'b00101;
   localparam logic [F_W-1:0] F_SUB = 5'b00110;
   localparam logic [F_W-1:0] F_SLT = 5'b00111;
   localparam logic [F_W-1:0] F_SRL = 5'b01100;
   localparam logic [F_W-1:0] F_SRA = 5'b01101;

   typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, DONE} mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared single-cycle combinational ALU; shifts act on operand b by shamt.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0]       a_i,
   input  logic [W-1:0]       b_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [F_W-1:0]     f_i,
   output logic [W-1:0]       y_o,
   output logic               zero_o
);

   // Function decode; unknown codes yield zero.
   always_comb begin
      y_o = '0;
      case (f_i)
         F_AND:   y_o = a_i & b_i;
         F_OR:    y_o = a_i | b_i;
         F_ADD:   y_o = a_i + b_i;
         F_SUB:   y_o = a_i - b_i;
         F_SLT:   y_o = W'($signed(a_i) < $signed(b_i));
         F_XOR:   y_o = a_i ^ b_i;
         F_NOR:   y_o = ~(a_i | b_i);
         F_SLL:   y_o = b_i << shamt_i;
         F_SRL:   y_o = b_i >> shamt_i;
         F_SRA:   y_o = W'($signed(b_i) >>> shamt_i);
         default: y_o = '0;
      endcase
   end

   assign zero_o = (y_o == '0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the shared ALU for every add and shift.
// The loop ends when the shifted multiplier reaches zero, so no iteration counter is needed.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [W-1:0]       op_a,
   input  logic [W-1:0]       op_b,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [W-1:0]       result,
   output logic               busy,
   output logic [W-1:0]       alu_a,
   output logic [W-1:0]       alu_b,
   output logic [SHAMT_W-1:0] alu_shamt,
   output logic [F_W-1:0]     alu_f,
   input  logic [W-1:0]       alu_y,
   input  logic               alu_zero
);

   mul_state_t   state_q, state_d;
   logic [W-1:0] prod_q,   prod_d;
   logic [W-1:0] mcand_q,  mcand_d;
   logic [W-1:0] mplier_q, mplier_d;

   // Next-state, datapath loads and state-decoded outputs (no input reaches an output).
   always_comb begin
      state_d    = state_q;
      prod_d     = prod_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      result     = '0;
      busy       = (state_q != IDLE);
      alu_f      = F_AND;
      alu_a      = '0;
      alu_b      = '0;
      alu_shamt  = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               prod_d   = '0;
               mcand_d  = op_a;
               mplier_d = op_b;
               state_d  = ADD;
            end
         end
         ADD: begin
            alu_f   = F_ADD;
            alu_a   = prod_q;
            alu_b   = mplier_q[0] ? mcand_q : '0;
            prod_d  = alu_y;
            state_d = SHL;
         end
         SHL: begin
            alu_f     = F_SLL;
            alu_b     = mcand_q;
            alu_shamt = SHAMT_W'(1);
            mcand_d   = alu_y;
            state_d   = SHR;
         end
         SHR: begin
            alu_f     = F_SRL;
            alu_b     = mplier_q;
            alu_shamt = SHAMT_W'(1);
            mplier_d  = alu_y;
            state_d   = alu_zero ? DONE : ADD;
         end
         DONE: begin
            resp_valid = 1'b1;
            result     = prod_q;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset that drops any in-flight request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and random checks of the multiplier sequencer wired to the real ALU.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   logic         clk;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         resp_valid;
   logic         resp_ready;
   logic [W-1:0] result;
   logic         busy;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [4:0]   alu_shamt;
   logic [4:0]   alu_f;
   logic [W-1:0] alu_y;
   logic         alu_zero;

   int errors;
   int checks;
   logic [4:0] ftrace[$];

   alu_mul_sequencer #(.W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .result     (result),
      .busy       (busy),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_shamt  (alu_shamt),
      .alu_f      (alu_f),
      .alu_y      (alu_y),
      .alu_zero   (alu_zero)
   );

   alu #(.W(W)) u_alu (
      .a_i     (alu_a),
      .b_i     (alu_b),
      .shamt_i (alu_shamt),
      .f_i     (alu_f),
      .y_o     (alu_y),
      .zero_o  (alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Iterations expected for a multiplier: index of highest set bit plus one, at least one.
   function automatic int iters(input logic [31:0] b);
      int n;
      n = 1;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      return n;
   endfunction

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      return p[31:0];
   endfunction

   // Offer a request from IDLE and wait for resp_valid; lat counts edges after acceptance.
   task automatic run(input logic [31:0] a, input logic [31:0] b, output int lat);
      ftrace.delete();
      req_valid = 1'b1;
      op_a      = a;
      op_b      = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 200) begin
         ftrace.push_back(alu_f);
         @(posedge clk); #1;
         lat++;
      end
      chk("resp_valid_seen", 32'(resp_valid), 32'd1);
   endtask

   task automatic take();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] held;
      logic [4:0]  pat[3];
      int hold;

      errors     = 0;
      checks     = 0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      op_a       = '0;
      op_b       = '0;
      pat[0] = F_ADD;
      pat[1] = F_SLL;
      pat[2] = F_SRL;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready",  32'(req_ready),  32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_result",     result,          32'd0);
      chk("rst_alu_f",      32'(alu_f),      32'd0);
      chk("rst_alu_a",      alu_a,           32'd0);
      chk("rst_alu_b",      alu_b,           32'd0);
      chk("rst_alu_shamt",  32'(alu_shamt),  32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 3 * 5 with function-code trace
      run(32'd3, 32'd5, lat);
      chk("m3x5_lat", 32'(lat), 32'd9);
      chk("m3x5_res", result, 32'd15);
      chk("m3x5_busy", 32'(busy), 32'd1);
      chk("m3x5_trace_len", 32'(ftrace.size()), 32'd9);
      for (int i = 0; i < ftrace.size() && i < 9; i++)
         chk("m3x5_trace", 32'(ftrace[i]), 32'(pat[i % 3]));
      take();
      chk("m3x5_idle", 32'(req_ready), 32'd1);

      // all-ones squared
      run(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      chk("ones_lat", 32'(lat), 32'd96);
      chk("ones_res", result, 32'h0000_0001);
      take();

      // zero and one multipliers
      run(32'h1234_5678, 32'd0, lat);
      chk("b0_lat", 32'(lat), 32'd3);
      chk("b0_res", result, 32'd0);
      take();
      run(32'h1234_5678, 32'd1, lat);
      chk("b1_lat", 32'(lat), 32'd3);
      chk("b1_res", result, 32'h1234_5678);
      take();

      // back-pressure with an ignored second request
      run(32'd7, 32'd6, lat);
      chk("bp_lat", 32'(lat), 32'd9);
      for (int i = 0; i < 10; i++) begin
         chk("bp_result", result, 32'd42);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_resp_valid", 32'(resp_valid), 32'd1);
         req_valid = (i >= 3 && i <= 5);
         op_a      = 32'd100;
         op_b      = 32'd100;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      take();
      chk("bp_req_ready_after", 32'(req_ready), 32'd1);
      chk("bp_busy_after", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("bp_not_queued", 32'(busy), 32'd0);

      // reset four cycles after acceptance
      req_valid = 1'b1;
      op_a      = 32'd9;
      op_b      = 32'd9;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_req_ready", 32'(req_ready), 32'd1);
      run(32'd2, 32'h8000_0000, lat);
      chk("mid_new_lat", 32'(lat), 32'd96);
      chk("mid_new_res", result, 32'd0);
      take();

      // random regression with random response hold-off
      for (int i = 0; i < 1000; i++) begin
         a    = $urandom;
         b    = $urandom >> $urandom_range(8, 31);
         hold = $urandom_range(0, 2);
         run(a, b, lat);
         chk("rand_lat", 32'(lat), 32'(3 * iters(b)));
         chk("rand_res", result, model(a, b));
         held = result;
         repeat (hold) @(posedge clk);
         #1;
         chk("rand_hold", result, held);
         take();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle multiplier controller that computes the low 32 bits of a 32×32 product. It does not contain its own adder or shifter. It drives the shared single-cycle ALU through its operand, shift-amount and function ports, issuing a shift-add sequence. It sits beside the MIPS datapath's ALU and takes requests over a valid/ready handshake. Results are returned over a second valid/ready handshake.

## Interface
Parameters:
- `W`, default 32: datapath width; must match the ALU operand width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: a request is offered.
- `req_ready`, out, 1: the block accepts a request this cycle (high only in IDLE).
- `op_a`, in, W: multiplicand.
- `op_b`, in, W: multiplier.
- `resp_valid`, out, 1: `result` is valid.
- `resp_ready`, in, 1: the consumer takes the result.
- `result`, out, W: low W bits of `op_a*op_b`.
- `busy`, out, 1: a request is in progress (state is not IDLE).
- `alu_a`, out, W: ALU operand a.
- `alu_b`, out, W: ALU operand b.
- `alu_shamt`, out, 5: ALU shift amount.
- `alu_f`, out, 5: ALU function code.
- `alu_y`, in, W: ALU result.
- `alu_zero`, in, 1: ALU zero flag.

## Operation
- Internal registers: `prod`, `mcand`, `mplier` (all W bits); `state`.
- State IDLE:
  - `req_ready=1`.
  - On `req_valid`: load `prod<=0`, `mcand<=op_a`, `mplier<=op_b`, then go to ADD.
- State ADD:
  - Drive `alu_f=F_ADD (00010)`, `alu_a=prod`, `alu_b = mplier[0] ? mcand : 0`.
  - Load `prod<=alu_y`, then go to SHL.
- State SHL:
  - Drive `alu_f=F_SLL (00011)`, `alu_b=mcand`, `alu_shamt=1`.
  - Load `mcand<=alu_y`, then go to SHR.
- State SHR:
  - Drive `alu_f=F_SRL (01100)`, `alu_b=mplier`, `alu_shamt=1`.
  - Load `mplier<=alu_y`.
  - If `alu_zero`, go to DONE; otherwise go to ADD.
- State DONE:
  - `resp_valid=1`, `result=prod`.
  - On `resp_ready`, go to IDLE.
- ALU drive outside ADD/SHL/SHR:
  - `alu_f=F_AND (00000)`, `alu_a=0`, `alu_b=0`, `alu_shamt=0`.
  - Operand ports not named for a state are also driven 0.
- Arithmetic:
  - Modulo 2^W with no overflow flag.
  - The result is sign-agnostic, so the low word is correct for both signed and unsigned operands.
- Boundary conditions:
  - `op_b=0`: one iteration runs, and the result is 0.
  - `op_b` with bit 31 set: exactly 32 iterations run.
  - `mplier` always reaches zero by the 32nd SHR, so there is no separate counter and the loop cannot hang.
  - `req_valid` outside IDLE is ignored and not queued, because `req_ready=0`.
  - `result` is held stable while `resp_valid` is high and `resp_ready` is low.
  - `reset` at any cycle, including mid-sequence: the next state is IDLE, the in-flight request is discarded, and no response is produced.

## Timing
- Reset values:
  - `state`: IDLE.
  - `req_ready`: 1.
  - `resp_valid`: 0.
  - `busy`: 0.
  - `result`: 0.
  - `prod`, `mcand`, `mplier`: 0.
  - ALU outputs: idle values.
- Acceptance happens on a clock edge E0 where `req_valid & req_ready`.
- Iteration count: N = max(1, h+1), where h is the index of the highest set bit of `op_b`.
- `resp_valid` rises in the cycle beginning at edge E0+3N:
  - Minimum 3 cycles (`op_b` = 0 or 1).
  - Maximum 96 cycles.
- A response is handed off on the edge where `resp_valid & resp_ready`.
- `req_ready` is high in the following cycle, which gives one idle cycle between back-to-back requests.
- All outputs are registered-state decodes: combinational from `state`, `prod`, `mcand`, `mplier`. No input-to-output combinational path exists.
- The ALU is combinational, so `alu_y` is sampled in the same cycle it is driven.

## Structure
- Shared package `alu_pkg`:
  - ALU function codes `F_AND=5'b00000`, `F_ADD=5'b00010`, `F_SLL=5'b00011`, `F_SRL=5'b01100`, plus the remaining codes for other clients.
  - `typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, DONE} mul_state_t`.
- The block itself has no sub-module.
- The verification top instantiates the `alu_mul_sequencer` together with the real `alu` so that the ALU protocol is exercised end to end.

## Test plan
- `op_a=3`, `op_b=5`:
  - `result=15`, `resp_valid` at E0+9.
  - `alu_f` sequence 00010, 00011, 01100 repeats exactly 3 times.
- `op_a=0xFFFFFFFF`, `op_b=0xFFFFFFFF`: `result=0x00000001`, `resp_valid` at E0+96.
- `op_a=0x12345678`, `op_b=0`: `result=0`, `resp_valid` at E0+3. Repeat with `op_b=1`: `result=0x12345678`, also at E0+3.
- Back-pressure:
  - `op_a=7`, `op_b=6` with `resp_ready` held low for 10 cycles.
  - `result=42` stays stable, `req_ready=0` throughout, and a second `req_valid` during this time is ignored.
  - Then raise `resp_ready`: `req_ready=1` on the next cycle.
- Reset mid-operation:
  - Assert `reset` 4 cycles after accepting `op_a=9`, `op_b=9`.
  - Next cycle: IDLE, `busy=0`, `resp_valid=0`.
  - A new request `op_a=2`, `op_b=0x80000000` then yields `result=0`.
- Random regression: 1000 random operand pairs with random `resp_ready`. Each `result` must equal `(op_a*op_b) mod 2^32`, and each latency must equal 3N.
